// File: rtl/ethernet_pkg.sv
// Shared Ethernet TX/RX definitions: FIFO word layout between the mux, the
// AXI-Stream bridges and the RX side, plus the TX bridge state encoding.
package ethernet_pkg;

  localparam int ETH_FIFO_W    = 74;
  localparam int ETH_TKEEP_W   = 8;
  localparam int ETH_TDATA_W   = 64;
  localparam int ETH_TKEEP_LSB = 66;
  localparam int ETH_TDATA_LSB = 2;
  localparam int ETH_TLAST_BIT = 1;
  localparam int ETH_TUSER_BIT = 0;

  // Field order matches {tkeep[73:66], tdata[65:2], tlast[1], tuser[0]}.
  typedef struct packed {
    logic [ETH_TKEEP_W-1:0] tkeep;
    logic [ETH_TDATA_W-1:0] tdata;
    logic                   tlast;
    logic                   tuser;
  } eth_fifo_word_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_FRAME = 2'd1,
    TX_DROP  = 2'd2
  } eth_tx_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer with registered outputs: an output register plus one
// overflow slot, so s_ready depends only on flop state.
module axis_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              push;
  logic              out_free;

  assign s_ready = !skid_valid_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

  always_comb begin
    push         = s_valid && s_ready;
    out_free     = !out_valid_q || m_ready;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = s_data;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
  end

  // NOTE: data registers are reset too, so downstream sees all-zero outputs after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/eth_tx_axis_bridge.sv
// Pops FWFT words from the TX mux and drives the MAC AXI-Stream port, dropping
// idle words, truncating oversize frames and counting completed frames.
module eth_tx_axis_bridge
  import ethernet_pkg::*;
#(
  parameter int MAX_BEATS = 190,
  parameter int CNT_W     = 32
) (
  input  logic                  clk156,
  input  logic                  eth_rst,
  output logic                  fifo_rd_en,
  input  logic [ETH_FIFO_W-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_W-1:0]      stat_frames,
  output logic [CNT_W-1:0]      stat_errors
);

  localparam logic [15:0] CAP_M1 = 16'(MAX_BEATS - 1);

  eth_fifo_word_t in_word, fwd_word, out_word;
  eth_tx_state_e  state_q, state_d;
  logic [15:0]    beat_q, beat_d;
  logic           err_q, err_d;
  logic [CNT_W-1:0] frames_q, frames_d, errors_q, errors_d;
  logic           idle_word, at_cap, skid_ready, push_valid, accept;

  assign in_word = fifo_dout;
  assign at_cap  = (state_q == TX_FRAME) && (beat_q == CAP_M1) && !in_word.tlast;

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state_q  <= TX_IDLE;
      beat_q   <= '0;
      err_q    <= 1'b0;
      frames_q <= '0;
      errors_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      frames_q <= frames_d;
      errors_q <= errors_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    if (fifo_rd_en) begin
      unique case (state_q)
        TX_IDLE: begin
          if (!idle_word) begin
            beat_d = 16'd1;
            err_d  = in_word.tuser && !in_word.tlast;
            if (!in_word.tlast) state_d = TX_FRAME;
          end
        end
        TX_FRAME: begin
          beat_d = beat_q + 16'd1;
          err_d  = err_q || in_word.tuser;
          if (in_word.tlast || at_cap) begin
            beat_d  = '0;
            err_d   = 1'b0;
            state_d = in_word.tlast ? TX_IDLE : TX_DROP;
          end
        end
        TX_DROP: begin
          if (in_word.tlast) state_d = TX_IDLE;
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    idle_word  = (state_q == TX_IDLE) && (in_word.tkeep == '0);
    fifo_rd_en = !fifo_empty && ((state_q == TX_DROP) || idle_word || skid_ready);
    push_valid = fifo_rd_en && (state_q != TX_DROP) && !idle_word;
    fwd_word       = in_word;
    fwd_word.tuser = in_word.tlast && (in_word.tuser || err_q);
    if (at_cap) begin
      fwd_word.tlast = 1'b1;
      fwd_word.tuser = 1'b1;
    end
  end

  axis_skid_buf #(.DATA_W(ETH_FIFO_W)) u_skid (
    .clk     (clk156),
    .rst     (eth_rst),
    .s_valid (push_valid),
    .s_ready (skid_ready),
    .s_data  (fwd_word),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (out_word)
  );

  always_comb begin
    accept   = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    frames_d = frames_q + CNT_W'(accept);
    errors_d = errors_q + CNT_W'(accept && m_axis_tuser);
  end

  assign m_axis_tdata = out_word.tdata;
  assign m_axis_tkeep = out_word.tkeep;
  assign m_axis_tlast = out_word.tlast;
  assign m_axis_tuser = out_word.tuser;
  assign stat_frames  = frames_q;
  assign stat_errors  = errors_q;

endmodule

// File: tb/tb_eth_tx_axis_bridge.sv
// Bench for eth_tx_axis_bridge: a FWFT FIFO model feeds frames, a frame-level
// reference model predicts MAC beats, and directed plus random steps check them.
module tb_eth_tx_axis_bridge;
  import ethernet_pkg::*;

  localparam int MAXB = 190;
  localparam int CW   = 32;

  logic          clk156 = 1'b0;
  logic          eth_rst;
  logic          fifo_rd_en;
  logic [73:0]   fifo_dout;
  logic          fifo_empty;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [CW-1:0] stat_frames;
  logic [CW-1:0] stat_errors;

  always #5 clk156 = ~clk156;

  eth_tx_axis_bridge #(.MAX_BEATS(MAXB), .CNT_W(CW)) dut (
    .clk156        (clk156),
    .eth_rst       (eth_rst),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .stat_frames   (stat_frames),
    .stat_errors   (stat_errors)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;
  eth_fifo_word_t fifo_q[$], frm[$], exp_q[$];
  eth_fifo_word_t held;
  int  cyc = 0, pops = 0, accepts = 0, occ_base = 0, rdy_idx = 0, rdy_mode = 0;
  int  first_pop, first_valid, first_acc, last_acc;
  int  exp_frames = 0, exp_errors = 0;
  bit  track_occ = 1'b0, hold_pend = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  function automatic eth_fifo_word_t mk(input logic [7:0] k, input bit last, input bit user);
    eth_fifo_word_t w;
    w.tkeep = k;
    w.tdata = {$urandom, $urandom};
    w.tlast = last;
    w.tuser = user;
    return w;
  endfunction

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0];
  endtask

  // Frame-level model: leading idle words vanish, at most MAXB beats survive,
  // an oversize frame ends in a forced error beat, tuser ORs into the last beat.
  task automatic load_frame();
    int s = 0;
    int len, n;
    bit err = 1'b0;
    eth_fifo_word_t b;
    foreach (frm[i]) fifo_q.push_back(frm[i]);
    while (s < frm.size() && frm[s].tkeep == 8'h00) s++;
    len = frm.size() - s;
    n   = (len > MAXB) ? MAXB : len;
    for (int i = 0; i < n; i++) begin
      b   = frm[s+i];
      err = err | b.tuser;
      if (i == n - 1) begin
        b.tlast = 1'b1;
        b.tuser = (len > MAXB) ? 1'b1 : err;
      end
      exp_q.push_back(b);
    end
    frm.delete();
    drive_fifo();
  endtask

  task automatic build(input int n, input int idles, input int user_pos, input bit allow_k0);
    logic [7:0] k;
    for (int i = 0; i < idles; i++) frm.push_back(mk(8'h00, 1'b0, 1'b0));
    for (int i = 0; i < n; i++) begin
      k = 8'($urandom_range(1, 255));
      if (allow_k0 && i > 0 && $urandom_range(0, 9) == 0) k = 8'h00;
      frm.push_back(mk(k, i == n - 1, i == user_pos));
    end
  endtask

  task automatic cycle();
    bit rd, acc;
    eth_fifo_word_t b;
    #1;
    rd  = fifo_rd_en;
    acc = m_axis_tvalid && m_axis_tready;
    if (hold_pend) begin
      check("hold_valid", m_axis_tvalid, 1'b1);
      check("hold_data", m_axis_tdata, held.tdata);
      check("hold_keep", m_axis_tkeep, held.tkeep);
    end
    if (track_occ) begin
      check("occ_le2", (pops - accepts - occ_base) <= 2, 1'b1);
      if (pops - accepts - occ_base == 2) check("rd_when_full", rd, 1'b0);
    end
    if (rd) check("rd_nonempty", fifo_empty, 1'b0);
    if (rd && first_pop < 0) first_pop = cyc;
    if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
    if (acc) begin
      check("beat_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        check("tdata", m_axis_tdata, b.tdata);
        check("tkeep", m_axis_tkeep, b.tkeep);
        check("tlast", m_axis_tlast, b.tlast);
        if (b.tlast) begin
          check("tuser_last", m_axis_tuser, b.tuser);
          exp_frames++;
          exp_errors += int'(b.tuser);
        end
      end
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    hold_pend = m_axis_tvalid && !m_axis_tready;
    held      = {m_axis_tkeep, m_axis_tdata, m_axis_tlast, m_axis_tuser};
    @(posedge clk156);
    cyc++;
    if (rd) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
    end
    if (acc) accepts++;
    #1;
    drive_fifo();
    rdy_idx++;
    case (rdy_mode)
      1:       m_axis_tready = (rdy_idx % 3 == 0);
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
  endtask

  task automatic drain(input int budget, input string tag);
    int c = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
      cycle();
      c++;
    end
    check(tag, c < budget, 1'b1);
    repeat (3) cycle();
  endtask

  task automatic mark();
    first_pop = -1; first_valid = -1; first_acc = -1; last_acc = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a0, c;
    eth_rst = 1'b1; fifo_empty = 1'b1; fifo_dout = '0; m_axis_tready = 1'b0;
    repeat (2) @(posedge clk156);
    #1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 64'h0);
    check("rst_tkeep", m_axis_tkeep, 8'h0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tuser", m_axis_tuser, 1'b0);
    check("rst_frames", stat_frames, 0);
    check("rst_errors", stat_errors, 0);
    eth_rst = 1'b0;
    m_axis_tready = 1'b1;

    // 3-beat frame, tready high
    mark();
    frm.push_back(mk(8'hFF, 1'b0, 1'b0));
    frm.push_back(mk(8'hFF, 1'b0, 1'b0));
    frm.push_back(mk(8'h0F, 1'b1, 1'b0));
    load_frame();
    drain(50, "t1_drain");
    check("t1_latency", first_valid - first_pop, 1);
    check("t1_back2back", last_acc - first_acc, 2);
    check("t1_frames", stat_frames, 1);
    check("t1_errors", stat_errors, 0);

    // two idle words then a single-beat frame
    p0 = pops; a0 = accepts;
    frm.push_back(mk(8'h00, 1'b0, 1'b0));
    frm.push_back(mk(8'h00, 1'b0, 1'b0));
    frm.push_back(mk(8'h3F, 1'b1, 1'b0));
    load_frame();
    drain(50, "t2_drain");
    check("t2_pops", pops - p0, 3);
    check("t2_beats", accepts - a0, 1);
    check("t2_frames", stat_frames, 2);

    // oversize frame truncated, then a normal frame
    p0 = pops; a0 = accepts;
    build(200, 0, -1, 1'b0);
    load_frame();
    drain(500, "t3_drain");
    check("t3_pops", pops - p0, 200);
    check("t3_beats", accepts - a0, MAXB);
    check("t3_errors", stat_errors, 1);
    build(3, 0, -1, 1'b0);
    load_frame();
    drain(50, "t3b_drain");
    check("t3b_frames", stat_frames, 4);
    check("t3b_errors", stat_errors, 1);

    // 5-beat frame under tready 1,0,0,1,...
    a0 = accepts;
    occ_base = pops - accepts; track_occ = 1'b1;
    rdy_mode = 1; rdy_idx = 0; m_axis_tready = 1'b1;
    build(5, 0, -1, 1'b0);
    load_frame();
    drain(100, "t4_drain");
    track_occ = 1'b0; rdy_mode = 0; m_axis_tready = 1'b1;
    check("t4_beats", accepts - a0, 5);
    check("t4_frames", stat_frames, 5);

    // tuser on beat 2 of 4
    build(4, 0, 1, 1'b0);
    load_frame();
    drain(50, "t5_drain");
    check("t5_frames", stat_frames, 6);
    check("t5_errors", stat_errors, 2);

    // reset at beat 2 of a 4-beat frame
    p0 = pops; c = 0;
    build(4, 0, -1, 1'b0);
    load_frame();
    while (pops - p0 < 2 && c < 20) begin cycle(); c++; end
    check("t6_reach_beat2", c < 20, 1'b1);
    eth_rst = 1'b1;
    fifo_q.delete(); exp_q.delete(); drive_fifo();
    @(posedge clk156);
    #1;
    eth_rst = 1'b0; hold_pend = 1'b0;
    exp_frames = 0; exp_errors = 0;
    check("t6_tvalid", m_axis_tvalid, 1'b0);
    check("t6_frames", stat_frames, 0);
    check("t6_errors", stat_errors, 0);
    build(3, 0, -1, 1'b0);
    load_frame();
    drain(50, "t6b_drain");
    check("t6b_frames", stat_frames, 1);

    // random frames, random idles, random tready
    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      int n;
      n = (f == 12) ? MAXB + 3 : $urandom_range(1, 12);
      build(n, $urandom_range(0, 2),
            ($urandom_range(0, 9) < 2) ? $urandom_range(0, n - 1) : -1, 1'b1);
      load_frame();
    end
    drain(5000, "t7_drain");
    check("t7_frames", stat_frames, exp_frames);
    check("t7_errors", stat_errors, exp_errors);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
